// File: rtl/program_load_controller.sv
// Boot-time program loader: assembles little-endian UART bytes into 32-bit words
// and writes them to instruction memory, then data memory, while holding the CPU.
module program_load_controller #(
   parameter int ADDR_W     = 14,
   parameter int IMEM_WORDS = 16384,
   parameter int DMEM_WORDS = 16384,
   parameter int TIMEOUT    = 10000000
) (
   input  logic              iFpgaClk,
   input  logic              iFpgaRst,
   input  logic              iStartReceiveCoe,
   input  logic              iRxValid,
   input  logic [7:0]        iRxByte,
   output logic              oCommMode,
   output logic              oMemWe,
   output logic              oMemSel,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic [31:0]       oMemWdata,
   output logic [15:0]       oWordCount,
   output logic              oLoadDone,
   output logic              oError
);

   localparam int TOTAL = IMEM_WORDS + DMEM_WORDS;
   localparam int TW    = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, RECV, WRITE, FINISH} state_t;

   state_t        state, state_nxt;
   logic          start_prev_low;
   logic          start_edge;
   logic [1:0]    k;
   logic [15:0]   w;
   logic [23:0]   asm_q;
   logic [TW-1:0] tcnt;
   logic          seen;
   logic          timeout_hit;
   logic          last_word;
   logic          we_int;

   // Edge needs start to have been seen low after reset, so a start held
   // through reset release does not launch a load.
   assign start_edge  = iStartReceiveCoe & start_prev_low;
   assign timeout_hit = seen & ~iRxValid & (tcnt == TW'(TIMEOUT - 1));
   assign last_word   = (w + 16'd1) == 16'(TOTAL);

   assign oMemSel    = w >= 16'(IMEM_WORDS);
   assign oMemAddr   = ADDR_W'(oMemSel ? (w - 16'(IMEM_WORDS)) : w);
   assign oWordCount = w;
   assign oMemWe     = we_int & iFpgaRst;

   always_ff @(posedge iFpgaClk) begin
      if (!iFpgaRst) state <= RUN;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      oCommMode = 1'b1;
      we_int    = 1'b0;
      oLoadDone = 1'b0;
      case (state)
         RUN: begin
            oCommMode = 1'b0;
            if (start_edge) state_nxt = RECV;
         end
         RECV: begin
            if (iRxValid && k == 2'd3) state_nxt = WRITE;
            else if (timeout_hit)      state_nxt = FINISH;
         end
         WRITE: begin
            we_int    = 1'b1;
            state_nxt = last_word ? FINISH : RECV;
         end
         FINISH: begin
            oLoadDone = 1'b1;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge iFpgaClk) begin
      if (!iFpgaRst) begin
         start_prev_low <= 1'b0;
         k              <= '0;
         w              <= '0;
         asm_q          <= '0;
         tcnt           <= '0;
         seen           <= 1'b0;
         oMemWdata      <= '0;
         oError         <= 1'b0;
      end else begin
         start_prev_low <= ~iStartReceiveCoe;
         case (state)
            RUN: begin
               if (start_edge) begin
                  k      <= '0;
                  w      <= '0;
                  tcnt   <= '0;
                  seen   <= 1'b0;
                  oError <= 1'b0;
               end
            end
            RECV: begin
               if (iRxValid) begin
                  k    <= k + 2'd1;
                  tcnt <= '0;
                  seen <= 1'b1;
                  if (k == 2'd3) oMemWdata <= {iRxByte, asm_q};
                  else           asm_q[{k, 3'b000} +: 8] <= iRxByte;
               end else if (seen) begin
                  if (timeout_hit) begin
                     oError <= (k != 2'd0);
                     k      <= '0;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
            end
            WRITE: begin
               w <= w + 16'd1;
               // A byte arriving alongside the write starts the next word.
               if (iRxValid && !last_word) begin
                  asm_q[7:0] <= iRxByte;
                  k          <= 2'd1;
                  tcnt       <= '0;
                  seen       <= 1'b1;
               end
            end
            FINISH: begin
               k    <= '0;
               tcnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/program_load_controller.md
PROGRAM_LOAD_CONTROLLER -- requirements
Module: program_load_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning word-address width of each memory.
REQ-002 SHALL have parameter IMEM_WORDS, default 16384, meaning words routed to instruction memory.
REQ-003 SHALL have parameter DMEM_WORDS, default 16384, meaning words routed to data memory after IMEM_WORDS.
REQ-004 SHALL have parameter TIMEOUT, default 10000000, meaning idle cycles between bytes that end a load.
REQ-005 SHALL have port iFpgaClk, input, 1, the single clock for all state.
REQ-006 SHALL have port iFpgaRst, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port iStartReceiveCoe, input, 1, start-load request, already synchronized level.
REQ-008 SHALL have port iRxValid, input, 1, one-cycle strobe qualifying iRxByte.
REQ-009 SHALL have port iRxByte, input, 8, received UART byte.
REQ-010 SHALL have port oCommMode, output, 1, 1 while loading; the CPU is held and memories are owned by this block.
REQ-011 SHALL have port oMemWe, output, 1, memory write strobe.
REQ-012 SHALL have port oMemSel, output, 1, 0 = instruction memory, 1 = data memory.
REQ-013 SHALL have port oMemAddr, output, ADDR_W, word address within the selected memory.
REQ-014 SHALL have port oMemWdata, output, 32, write data.
REQ-015 SHALL have port oWordCount, output, 16, number of words written in the current or last load.
REQ-016 SHALL have port oLoadDone, output, 1, one-cycle pulse when a load ends.
REQ-017 SHALL have port oError, output, 1, sticky flag: the last load ended on a partial word.

Function
REQ-018 SHALL implement states RUN, RECV, WRITE and FINISH.
REQ-019 In RUN, oCommMode SHALL be 0; a rising edge of iStartReceiveCoe (registered compare) SHALL enter RECV and clear the byte index, word index, timeout counter, oWordCount and oError.
REQ-020 In RECV, WRITE and FINISH, oCommMode SHALL be 1; start edges there SHALL be ignored.
REQ-021 In RECV, each iRxValid SHALL store iRxByte at assembly bits [8*k+7:8*k] for byte index k (little-endian, byte 0 first) and increment k.
REQ-022 The 4th byte (k=3) SHALL move the state to WRITE on the next cycle with the complete word latched into oMemWdata.
REQ-023 In WRITE, oMemWe SHALL be 1 for exactly one cycle, with oMemSel = (w >= IMEM_WORDS) and oMemAddr = w, or w - IMEM_WORDS when oMemSel = 1, truncated to ADDR_W, where w is the word index.
REQ-024 WRITE SHALL increment w and oWordCount; if w+1 = IMEM_WORDS+DMEM_WORDS, the next state SHALL be FINISH, otherwise RECV.
REQ-025 An iRxValid during WRITE SHALL be captured as byte 0 of the next word; no byte SHALL be lost.
REQ-026 The timeout counter SHALL reset on every iRxValid and count in RECV only; it SHALL not count before the first byte of a load.
REQ-027 On the timeout counter reaching TIMEOUT in RECV: if k = 0, go to FINISH with oError = 0; if k != 0, discard the partial word and go to FINISH with oError = 1.
REQ-028 FINISH SHALL last one cycle with oLoadDone = 1, then return to RUN.
REQ-029 oMemWe SHALL be 0 in every state except WRITE.
REQ-030 The word index SHALL be 16 bits wide; IMEM_WORDS+DMEM_WORDS SHALL be at most 65535.

Reset
REQ-031 When iFpgaRst = 0 at a clock edge, the state SHALL go to RUN, with oCommMode=0, oMemWe=0, oMemSel=0, oMemAddr=0, oMemWdata=0, oWordCount=0, oLoadDone=0, oError=0, and all internal counters at 0.
REQ-032 Reset during RECV or WRITE SHALL abort the load immediately; no oMemWe SHALL be issued in or after the reset cycle.
REQ-033 The start-edge detector SHALL reset to 0, so a start held high through reset release SHALL NOT begin a load.

Verification (IMEM_WORDS=2, DMEM_WORDS=2, TIMEOUT=20)
REQ-034 Start edge, then bytes 78 56 34 12 -> one oMemWe with sel=0, addr=0, wdata=0x12345678, and oWordCount=1.
REQ-035 16 bytes -> writes at (sel,addr) = (0,0), (0,1), (1,0), (1,1) -> FINISH, oLoadDone pulse, oWordCount=4, oCommMode back to 0.
REQ-036 4 bytes, then 20 idle cycles -> oLoadDone, oError=0, oWordCount=1; 6 bytes, then idle -> one write, oError=1.
REQ-037 A byte strobed in the same cycle as a WRITE -> appears in bits [7:0] of the following written word.
REQ-038 iFpgaRst low after 2 bytes -> all outputs at reset values, no write; a later start edge with 4 bytes -> write at addr 0.
